// File: rtl/spi_master_multi_if.sv
// ---------------------------------------------------------------------------
// spi_master_multi_if
//   Bundles the host handshake and the SPI pin signals of spi_master_multi.
//   The signal names keep the block's external port names so the pin list
//   reads the same whether seen through the interface or on a schematic.
//
//   Parameters:
//     DATA_W  bits per transfer word (>= 2)
//     DVSR_W  width of the clock divisor input
//     NUM_SS  number of active-low slave-select lines (>= 1)
//
//   Host side:  din_i, dvsr_i, start_i, cpol_i, cpha_i, lsb_first_i, ss_sel_i
//               -> dout_o, ready_o, spi_done_tick_o
//   SPI pins:   miso_i -> sclk_o, mosi_o, ss_n_o
//
//   Modports:
//     master  view of the SPI master itself (drives the outputs)
//     slave   view of whatever sits around the master (host plus SPI slave)
// ---------------------------------------------------------------------------
interface spi_master_multi_if #(
  parameter int DATA_W = 8,
  parameter int DVSR_W = 16,
  parameter int NUM_SS = 4
);

  localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  logic [DATA_W-1:0] din_i;
  logic [DVSR_W-1:0] dvsr_i;
  logic              start_i;
  logic              cpol_i;
  logic              cpha_i;
  logic              lsb_first_i;
  logic [SS_W-1:0]   ss_sel_i;
  logic              miso_i;
  logic [DATA_W-1:0] dout_o;
  logic              sclk_o;
  logic              mosi_o;
  logic [NUM_SS-1:0] ss_n_o;
  logic              ready_o;
  logic              spi_done_tick_o;

  modport master (
    input  din_i, dvsr_i, start_i, cpol_i, cpha_i, lsb_first_i, ss_sel_i, miso_i,
    output dout_o, sclk_o, mosi_o, ss_n_o, ready_o, spi_done_tick_o
  );

  modport slave (
    output din_i, dvsr_i, start_i, cpol_i, cpha_i, lsb_first_i, ss_sel_i, miso_i,
    input  dout_o, sclk_o, mosi_o, ss_n_o, ready_o, spi_done_tick_o
  );

endinterface

// File: rtl/spi_master_multi.sv
// ---------------------------------------------------------------------------
// spi_master_multi
//   Parametrised SPI master: configurable word width, all four CPOL/CPHA
//   modes, MSB- or LSB-first shifting and NUM_SS one-hot active-low slave
//   selects. A single-cycle start_i (honoured only while ready_o=1) latches
//   the word and the transfer configuration; the received word appears on
//   dout_o together with a one-cycle spi_done_tick_o.
//
//   Ports:
//     clk_i    system clock
//     reset_i  asynchronous active-high reset
//     bus      spi_master_multi_if.master
//                din_i/dvsr_i/cpol_i/cpha_i/lsb_first_i/ss_sel_i  latched on start
//                start_i          transfer request
//                miso_i           serial data from slave
//                dout_o           last received word, held until next done
//                sclk_o/mosi_o    SPI clock and serial data to slave
//                ss_n_o           active-low slave selects
//                ready_o          idle, a start would be accepted
//                spi_done_tick_o  one-cycle pulse on transfer end
//
//   Timing: every SCLK half period (phase) lasts H = dvsr+1 clk_i cycles.
//   A transfer takes 2*DATA_W*H cycles, plus H when cpha=1.
//
//   Optional feature macro: SPI_CS_GUARD_EN
//     When defined, a TAIL phase of H cycles follows the last bit with SCLK
//     idle and the slave still selected; done, dout update and slave
//     deselect move to the end of TAIL.
// ---------------------------------------------------------------------------
module spi_master_multi #(
  parameter int DATA_W = 8,
  parameter int DVSR_W = 16,
  parameter int NUM_SS = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  spi_master_multi_if.master bus
);

  localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int BIT_W = $clog2(DATA_W);

  // CPHA_DLY is the half period of idle SCLK that cpha=1 needs before the
  // first leading edge. P0/P1 are the two halves of each SCLK period; which
  // of them drives SCLK active depends on cpha. TAIL only exists with the
  // chip-select guard build.
  typedef enum logic [2:0] {
    IDLE,
    CPHA_DLY,
    P0,
    P1,
    TAIL
  } state_t;

  state_t            state;
  logic [DVSR_W-1:0] cnt;
  logic [DVSR_W-1:0] dvsr_r;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_reg;
  logic [DATA_W-1:0] rx_reg;
  logic [DATA_W-1:0] dout_r;
  logic              cpol_r;
  logic              cpha_r;
  logic              lsb_r;
  logic              sclk_r;
  logic              mosi_r;
  logic [NUM_SS-1:0] ss_n_r;
  logic              ready_r;
  logic              done_r;

  logic              phase_end;
  logic              last_bit;
  logic [DATA_W-1:0] tx_shifted;
  logic              tx_next_bit;
  logic [DATA_W-1:0] rx_shifted;

  // Decode a slave index to the active-low select vector. An index beyond
  // NUM_SS-1 matches no line, so the transfer runs with nobody selected.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
    logic [NUM_SS-1:0] mask;
    mask = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (int'(sel) == i) mask[i] = 1'b0;
    end
    return mask;
  endfunction

  // Phase timing and the next-bit views of both shift registers. The
  // direction follows the latched lsb_first so transmit and receive always
  // agree on bit order.
  always_comb begin
    phase_end   = (cnt == dvsr_r);
    last_bit    = (bit_cnt == BIT_W'(DATA_W - 1));
    tx_shifted  = lsb_r ? (tx_reg >> 1) : (tx_reg << 1);
    tx_next_bit = lsb_r ? tx_reg[1] : tx_reg[DATA_W-2];
    rx_shifted  = lsb_r ? {bus.miso_i, rx_reg[DATA_W-1:1]}
                        : {rx_reg[DATA_W-2:0], bus.miso_i};
  end

  // Transfer sequencer. All pin-facing outputs are registered and are
  // written together with the state they belong to, so SCLK, MOSI and the
  // selects change on the same clk_i edge as the state itself.
  //   SCLK level per state: IDLE/CPHA_DLY/TAIL idle (cpol),
  //   P0 = cpol ^ cpha, P1 = cpol ^ ~cpha.
  // Receive sampling happens on P0 expiry, transmit shifting on P1 expiry;
  // with cpha=0 that is leading/trailing edge, with cpha=1 the P1 expiry is
  // the next leading edge, so data changes on leading and is sampled on
  // trailing edges.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= IDLE;
      cnt     <= '0;
      dvsr_r  <= '0;
      bit_cnt <= '0;
      tx_reg  <= '0;
      rx_reg  <= '0;
      dout_r  <= '0;
      cpol_r  <= 1'b0;
      cpha_r  <= 1'b0;
      lsb_r   <= 1'b0;
      sclk_r  <= 1'b0;
      mosi_r  <= 1'b0;
      ss_n_r  <= '1;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          sclk_r <= cpol_r;
          if (bus.start_i) begin
            dvsr_r  <= bus.dvsr_i;
            cpol_r  <= bus.cpol_i;
            cpha_r  <= bus.cpha_i;
            lsb_r   <= bus.lsb_first_i;
            tx_reg  <= bus.din_i;
            rx_reg  <= '0;
            cnt     <= '0;
            bit_cnt <= '0;
            mosi_r  <= bus.lsb_first_i ? bus.din_i[0] : bus.din_i[DATA_W-1];
            ss_n_r  <= ss_decode(bus.ss_sel_i);
            ready_r <= 1'b0;
            // Both first states hold SCLK at the new idle level.
            sclk_r  <= bus.cpol_i;
            state   <= bus.cpha_i ? CPHA_DLY : P0;
          end
        end

        CPHA_DLY: begin
          if (phase_end) begin
            cnt    <= '0;
            sclk_r <= ~cpol_r;
            state  <= P0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        P0: begin
          if (phase_end) begin
            cnt    <= '0;
            rx_reg <= rx_shifted;
            sclk_r <= cpol_r ^ ~cpha_r;
            state  <= P1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        P1: begin
          if (phase_end) begin
            cnt <= '0;
            if (last_bit) begin
              sclk_r <= cpol_r;
`ifdef SPI_CS_GUARD_EN
              state  <= TAIL;
`else
              dout_r  <= rx_reg;
              done_r  <= 1'b1;
              ready_r <= 1'b1;
              ss_n_r  <= '1;
              state   <= IDLE;
`endif
            end else begin
              tx_reg  <= tx_shifted;
              mosi_r  <= tx_next_bit;
              bit_cnt <= bit_cnt + 1'b1;
              sclk_r  <= cpol_r ^ cpha_r;
              state   <= P0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef SPI_CS_GUARD_EN
        // Keep the slave selected with SCLK idle for one extra half period
        // so the slave sees a clean hold time before chip select rises.
        TAIL: begin
          if (phase_end) begin
            cnt     <= '0;
            dout_r  <= rx_reg;
            done_r  <= 1'b1;
            ready_r <= 1'b1;
            ss_n_r  <= '1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        default: begin
          state   <= IDLE;
          ready_r <= 1'b1;
          ss_n_r  <= '1;
          sclk_r  <= cpol_r;
        end
      endcase
    end
  end

  assign bus.dout_o          = dout_r;
  assign bus.sclk_o          = sclk_r;
  assign bus.mosi_o          = mosi_r;
  assign bus.ss_n_o          = ss_n_r;
  assign bus.ready_o         = ready_r;
  assign bus.spi_done_tick_o = done_r;

endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
Parametrised SPI master, successor to the 8-bit mode-0 SPI master. Adds configurable word width, all four CPOL/CPHA modes, MSB- or LSB-first shifting and NUM_SS one-hot active-low slave selects. A host starts a transfer with a single-cycle start request. The block returns the received word with a one-cycle done tick. It sits between the host/bus logic and the external SPI pins.

Parameters:
DATA_W, 8, bits per transfer word (>=2)
DVSR_W, 16, width of clock divisor input
NUM_SS, 4, number of slave-select lines (>=1)

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous active-high reset
din_i  in  DATA_W  word to transmit, latched on accepted start
dvsr_i  in  DVSR_W  half SCLK period minus one, in clk_i cycles; latched on start
start_i  in  1  transfer request, honoured only while ready_o=1
cpol_i  in  1  SCLK idle level, latched on start
cpha_i  in  1  clock phase, latched on start
lsb_first_i  in  1  1 = shift LSB first, latched on start
ss_sel_i  in  max(1,$clog2(NUM_SS))  index of slave to select, latched on start
miso_i  in  1  serial data from slave
dout_o  out  DATA_W  last received word, held until next done
sclk_o  out  1  SPI clock
mosi_o  out  1  serial data to slave
ss_n_o  out  NUM_SS  active-low slave selects
ready_o  out  1  idle, start accepted
spi_done_tick_o  out  1  one-cycle pulse at transfer end

Behaviour:
- Reset (async, immediate): state IDLE. dout_o=0, sclk_o=0, mosi_o=0, ss_n_o=all 1, ready_o=1, spi_done_tick_o=0. All latched config cleared (cpol=0).
- H = dvsr+1 clk_i cycles (phase length). dvsr=0 gives H=1.
- IDLE: ready_o=1 and sclk_o=latched cpol. start_i=1 latches din/dvsr/cpol/cpha/lsb_first/ss_sel, clears counters and goes to CPHA_DLY if cpha=1, else P0. ready_o drops the next cycle.
- ss_n_o[ss_sel]=0 from the cycle after the accepted start until IDLE is re-entered. If ss_sel>=NUM_SS, the transfer still runs and no line is asserted.
- mosi_o = shift-register MSB (LSB if lsb_first), valid from the cycle after start.
- CPHA_DLY: H cycles with SCLK at idle level, then P0.
- P0 (H cycles): at expiry, sample miso_i into the receive shift register and go to P1.
- P1 (H cycles): at expiry, if bit_cnt=DATA_W-1, go to IDLE. Otherwise shift the tx register, bit_cnt++, and return to P0.
- sclk_o = cpol XOR ((P1 & ~cpha) | (P0 & cpha)). Edge order:
  - cpha=0: sampling happens on the leading edge.
  - cpha=1: data changes on the leading edge and is sampled on the trailing edge.
- Receive assembly follows lsb_first: the first received bit lands in the MSB (or LSB if lsb_first).
- Done: spi_done_tick_o=1 for exactly one cycle, on the cycle IDLE is entered. dout_o updates that same cycle. ready_o=1 and ss_n_o deasserts that same cycle.
- Latency from the start-sampled edge to the done pulse is 2*DATA_W*H + cpha*H cycles. Exactly DATA_W SCLK cycles are produced.
- start_i while busy is ignored with no side effects.
- start_i in the done cycle is accepted, giving a back-to-back transfer. SCLK returns to idle level for at least one cycle between the two transfers.
- Input changes after latching do not affect an in-flight transfer.

Optional Feature:
SPI_CS_GUARD_EN
- Defined: after the final P1 expiry, enter state TAIL for H cycles. During TAIL, SCLK is idle, ss_n stays asserted and ready_o=0. The done tick, dout update and ss_n deassert move to the end of TAIL. Latency grows by H.
- Undefined: no TAIL state; timing is as above.

Test Plan:
- Mode 0, DATA_W=8, dvsr=9, din=0xA5, MSB first, miso looped to mosi -> dout=0xA5, 8 rising SCLK edges, done exactly 160 cycles after start, ss_n_o=4'b1110 during transfer.
- Mode 3 (cpol=1, cpha=1), din=0x3C, slave drives 0xC3 changing on falling edges -> dout=0xC3, sclk idle high, done at 170 cycles.
- lsb_first=1, mode 1, din=0x01, ss_sel=2 -> first mosi bit 1 then seven 0s, ss_n_o=4'b1011, dout equals looped 0x01.
- Pulse start_i mid-transfer with din=0xFF -> ignored, original word completes, exactly one done pulse.
- Assert reset_i mid-P1 -> outputs return to reset values immediately, ss_n all 1. A new start after release completes normally.
- DATA_W=16, dvsr=0, back-to-back start in the done cycle, din=0xBEEF then 0x1234 -> two done pulses 32 cycles apart (plus the idle gap), dout matches each looped word.
